// File: rtl/yutorina_bus_slave_ram.sv
// +----------------------------------------------------------------------------+
// | Module      : yutorina_bus_slave_ram                                       |
// | Description : Bus slave responder terminating one slot with a word RAM,    |
// |               programmable wait states and an active-low ready strobe.     |
// |               Optional YUTORINA_BUS_SLAVE_RANGE_CHECK_EN rejects addresses |
// |               whose s_addr[7:0] >= DEPTH instead of wrapping them.         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module yutorina_bus_slave_ram #(
  parameter int DEPTH       = 16,
  parameter int ADDR_W      = 4,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        s_cs_,
  input  logic        s_as_,
  input  logic        s_rw,
  input  logic [29:0] s_addr,
  input  logic [31:0] s_wr_data,
  output logic [31:0] s_rd_data,
  output logic        s_rdy_
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

  localparam logic [3:0] C_WAIT = 4'(WAIT_CYCLES);

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                rw_q, rw_d;
  logic [31:0]         data_q, data_d;
  logic                oor_q, oor_d;
  logic                rdy_n_q, rdy_n_d;
  logic [31:0]         rd_data_q, rd_data_d;
  logic [31:0]         mem_q [DEPTH];
  logic                mem_we;
  logic                req;
  logic                addr_oor;
  logic                unused_addr_bits;

  assign req = ~s_cs_ & ~s_as_;
  assign unused_addr_bits = ^s_addr;

`ifdef YUTORINA_BUS_SLAVE_RANGE_CHECK_EN
  assign addr_oor = ({1'b0, s_addr[7:0]} >= 9'(DEPTH));
`else
  assign addr_oor = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    rw_d      = rw_q;
    data_d    = data_q;
    oor_d     = oor_q;
    rdy_n_d   = 1'b1;
    rd_data_d = 32'd0;
    mem_we    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          addr_d  = s_addr[ADDR_W-1:0];
          rw_d    = s_rw;
          data_d  = s_wr_data;
          oor_d   = addr_oor;
          cnt_d   = C_WAIT;
          state_d = (C_WAIT == 4'd0) ? ST_ACK : ST_WAIT;
        end
      end
      ST_WAIT: begin
        // Abort takes priority over the counter reaching its last wait state.
        if (!req) begin
          state_d = ST_IDLE;
          cnt_d   = 4'd0;
        end else if (cnt_q <= 4'd1) begin
          state_d = ST_ACK;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_ACK: begin
        state_d = ST_IDLE;
        rdy_n_d = 1'b0;
        if (rw_q) begin
          rd_data_d = oor_q ? 32'd0 : mem_q[addr_q];
        end else begin
          mem_we = ~oor_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 4'd0;
      addr_q    <= '0;
      rw_q      <= 1'b0;
      data_q    <= 32'd0;
      oor_q     <= 1'b0;
      rdy_n_q   <= 1'b1;
      rd_data_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      rw_q      <= rw_d;
      data_q    <= data_d;
      oor_q     <= oor_d;
      rdy_n_q   <= rdy_n_d;
      rd_data_q <= rd_data_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 32'd0;
      end
    end else if (mem_we) begin
      mem_q[addr_q] <= data_q;
    end
  end

  assign s_rdy_    = rdy_n_q;
  assign s_rd_data = rd_data_q;

endmodule

`default_nettype wire

// File: tb/tb_yutorina_bus_slave_ram.sv
// +----------------------------------------------------------------------------+
// | Module      : tb_yutorina_bus_slave_ram                                    |
// | Description : Self-checking bench: three slaves (0, 1 and 3 wait states),  |
// |               vector table, hand-written corner sequences, random traffic. |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_yutorina_bus_slave_ram;

`ifdef YUTORINA_BUS_SLAVE_RANGE_CHECK_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif

  logic              clk;
  logic              reset;
  logic [2:0]        cs_n;
  logic [2:0]        as_n;
  logic [2:0]        rw;
  logic [2:0][29:0]  addr;
  logic [2:0][31:0]  wdata;
  logic [2:0][31:0]  rdata;
  logic [2:0]        rdy_n;

  int waits [3] = '{0, 1, 3};
  logic [31:0] ref_mem [3][16];
  int checks = 0;
  int errors = 0;

  yutorina_bus_slave_ram #(.DEPTH(16), .ADDR_W(4), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .reset(reset), .s_cs_(cs_n[0]), .s_as_(as_n[0]), .s_rw(rw[0]),
    .s_addr(addr[0]), .s_wr_data(wdata[0]), .s_rd_data(rdata[0]), .s_rdy_(rdy_n[0]));
  yutorina_bus_slave_ram #(.DEPTH(16), .ADDR_W(4), .WAIT_CYCLES(1)) u_dut1 (
    .clk(clk), .reset(reset), .s_cs_(cs_n[1]), .s_as_(as_n[1]), .s_rw(rw[1]),
    .s_addr(addr[1]), .s_wr_data(wdata[1]), .s_rd_data(rdata[1]), .s_rdy_(rdy_n[1]));
  yutorina_bus_slave_ram #(.DEPTH(16), .ADDR_W(4), .WAIT_CYCLES(3)) u_dut3 (
    .clk(clk), .reset(reset), .s_cs_(cs_n[2]), .s_as_(as_n[2]), .s_rw(rw[2]),
    .s_addr(addr[2]), .s_wr_data(wdata[2]), .s_rd_data(rdata[2]), .s_rdy_(rdy_n[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic clear_model();
    for (int k = 0; k < 3; k++)
      for (int i = 0; i < 16; i++)
        ref_mem[k][i] = 32'd0;
  endtask

  // Reference: word index is the low 4 bits; with range checking, any
  // s_addr[7:0] of 16 or more is a read-as-zero / write-ignored location.
  function automatic logic [31:0] model(input int k, input logic r,
                                        input logic [29:0] a, input logic [31:0] wd);
    int  idx;
    bit  oor;
    idx = int'(a % 30'd16);
    oor = RC && ((a % 30'd256) >= 30'd16);
    if (r) return oor ? 32'd0 : ref_mem[k][idx];
    if (!oor) ref_mem[k][idx] = wd;
    return 32'd0;
  endfunction

  // Called just after a rising edge; returns data and latency in cycles after acceptance.
  task automatic txn(input int k, input logic r, input logic [29:0] a, input logic [31:0] wd,
                     output logic [31:0] rd, output int lat);
    cs_n[k] = 1'b0; as_n[k] = 1'b0; rw[k] = r; addr[k] = a; wdata[k] = wd;
    rd = 32'd0; lat = -1;
    @(posedge clk);
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (rdy_n[k] == 1'b0) begin
        rd  = rdata[k];
        lat = c;
        break;
      end
    end
    cs_n[k] = 1'b1; as_n[k] = 1'b1;
    @(negedge clk);
    check("after_ack_rdy", {31'd0, rdy_n[k]}, 32'd1);
    check("after_ack_data", rdata[k], 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic run_and_check(input int k, input logic r, input logic [29:0] a,
                               input logic [31:0] wd, input logic [31:0] exp);
    logic [31:0] rd;
    int          lat;
    txn(k, r, a, wd, rd, lat);
    check(r ? "read_latency" : "write_latency", 32'(lat), 32'(waits[k] + 1));
    if (r) check("read_data", rd, exp);
  endtask

  typedef struct {
    int          k;
    logic        r;
    logic [29:0] a;
    logic [31:0] wd;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl [9];

  initial begin
    int          seen;
    logic [31:0] e;
    logic [29:0] ra;

    tbl[0] = '{1, 1'b0, 30'h5,  32'hDEADBEEF, 32'h0};
    tbl[1] = '{1, 1'b1, 30'h5,  32'h0,        32'hDEADBEEF};
    tbl[2] = '{0, 1'b0, 30'h0,  32'h12345678, 32'h0};
    tbl[3] = '{0, 1'b1, 30'h0,  32'h0,        32'h12345678};
    tbl[4] = '{1, 1'b0, 30'h3,  32'h00000055, 32'h0};
    tbl[5] = '{1, 1'b0, 30'h13, 32'h00000011, 32'h0};
    tbl[6] = '{1, 1'b1, 30'h3,  32'h0,        RC ? 32'h55 : 32'h11};
    tbl[7] = '{1, 1'b1, 30'h13, 32'h0,        RC ? 32'h0  : 32'h11};
    tbl[8] = '{2, 1'b0, 30'h2,  32'h600DCAFE, 32'h0};

    reset = 1'b1;
    cs_n = '1; as_n = '1; rw = '0; addr = '0; wdata = '0;
    clear_model();
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check("reset_rdy", {31'd0, rdy_n[k]}, 32'd1);
      check("reset_data", rdata[k], 32'd0);
    end
    reset = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 9; i++) begin
      e = model(tbl[i].k, tbl[i].r, tbl[i].a, tbl[i].wd);
      run_and_check(tbl[i].k, tbl[i].r, tbl[i].a, tbl[i].wd, tbl[i].exp);
    end

    // Abort during wait states: no ready, no write.
    cs_n[2] = 1'b0; as_n[2] = 1'b0; rw[2] = 1'b0; addr[2] = 30'h2; wdata[2] = 32'hA5A5A5A5;
    @(posedge clk); #1;
    cs_n[2] = 1'b1; as_n[2] = 1'b1;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (rdy_n[2] == 1'b0) seen++;
    end
    check("abort_no_rdy", 32'(seen), 32'd0);
    @(posedge clk); #1;
    run_and_check(2, 1'b1, 30'h2, 32'h0, 32'h600DCAFE);

    // Reset pulse while a write sits in wait states.
    cs_n[2] = 1'b0; as_n[2] = 1'b0; rw[2] = 1'b0; addr[2] = 30'h9; wdata[2] = 32'h77;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    cs_n[2] = 1'b1; as_n[2] = 1'b1;
    #2 reset = 1'b0;
    clear_model();
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (rdy_n[2] == 1'b0) seen++;
    end
    check("reset_wait_no_rdy", 32'(seen), 32'd0);
    @(posedge clk); #1;
    run_and_check(2, 1'b1, 30'h9, 32'h0, 32'h0);

    // Asynchronous reset in the middle of a ready cycle.
    e = model(0, 1'b0, 30'h7, 32'hCAFEF00D);
    run_and_check(0, 1'b0, 30'h7, 32'hCAFEF00D, 32'h0);
    cs_n[0] = 1'b0; as_n[0] = 1'b0; rw[0] = 1'b1; addr[0] = 30'h7;
    @(posedge clk);
    @(posedge clk); #2;
    check("ack_rdy_before_reset", {31'd0, rdy_n[0]}, 32'd0);
    check("ack_data_before_reset", rdata[0], 32'hCAFEF00D);
    reset = 1'b1;
    #1;
    check("async_reset_rdy", {31'd0, rdy_n[0]}, 32'd1);
    check("async_reset_data", rdata[0], 32'd0);
    cs_n[0] = 1'b1; as_n[0] = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    clear_model();
    @(posedge clk); #1;
    run_and_check(0, 1'b1, 30'h3, 32'h0, 32'h0);
    run_and_check(0, 1'b1, 30'h7, 32'h0, 32'h0);
    run_and_check(1, 1'b1, 30'h5, 32'h0, 32'h0);

    // Random traffic against the reference model.
    for (int n = 0; n < 80; n++) begin
      int          k;
      logic        r;
      logic [31:0] wd;
      k  = int'($urandom_range(0, 2));
      r  = 1'($urandom_range(0, 1));
      ra = 30'($urandom());
      if ($urandom_range(0, 1) == 1) ra[29:5] = '0;
      wd = $urandom();
      e  = model(k, r, ra, wd);
      run_and_check(k, r, ra, wd, e);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
